stc_counter: RTL and testbench

System Time Clock (STC) for the MPEG-2 TS QoS path. The block counts rising edges of the 27 MHz divider output, which it samples in the `clk2` domain, and keeps a 42-bit PCR-format time (33-bit base, 9-bit extension). It accepts STC loads from the PCR extractor. It also compares received PCRs against the local STC in a 3-stage pipeline and reports signed drift plus a PCR accuracy violation flag.

---
 rtl/stc_counter.sv | 166 ++++++++++++++++
 tb/tb_stc_counter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stc_counter.sv
// -----------------------------------------------------------------------------
// stc_counter
//
// System Time Clock for the MPEG-2 TS QoS path.
// - Counts rising edges of a 27 MHz square wave sampled in the clk2 domain.
// - Keeps a 42-bit PCR-format time: a 33-bit base plus a 9-bit extension
//   (0..299).
// - Accepts STC loads from the PCR extractor.
// - Compares received PCRs against the local STC in a 3-stage pipeline and
//   reports the signed drift and an accuracy-violation flag.
//
// Ports
//   clk2        in   1   system clock (108 MHz)
//   rstn        in   1   synchronous active-low reset
//   clk_27_in   in   1   27 MHz square wave, already in the clk2 domain
//   load_valid  in   1   single-cycle STC load request
//   load_base   in  33   base value to load
//   load_ext    in   9   extension value to load (0..299 accepted)
//   check_valid in   1   single-cycle strobe carrying a received PCR
//   check_base  in  33   received PCR base
//   check_ext   in   9   received PCR extension
//   stc_base    out 33   current STC base
//   stc_ext     out  9   current STC extension
//   load_err    out  1   one-cycle pulse: load rejected (load_ext > 299)
//   delta_valid out  1   one-cycle pulse qualifying delta / ac_err
//   delta       out 43   signed drift in ticks (received PCR minus STC)
//   ac_err      out  1   |delta| > AC_LIMIT, qualified by delta_valid
// -----------------------------------------------------------------------------
module stc_counter #(
    parameter int AC_LIMIT = 14
) (
    input  logic        clk2,
    input  logic        rstn,
    input  logic        clk_27_in,
    input  logic        load_valid,
    input  logic [32:0] load_base,
    input  logic [8:0]  load_ext,
    input  logic        check_valid,
    input  logic [32:0] check_base,
    input  logic [8:0]  check_ext,
    output logic [32:0] stc_base,
    output logic [8:0]  stc_ext,
    output logic        load_err,
    output logic        delta_valid,
    output logic [42:0] delta,
    output logic        ac_err
);

    // One full wrap of the 42-bit PCR time: 2^33 * 300 ticks.
    localparam logic signed [42:0] MOD      = 43'sd2576980377600;
    localparam logic signed [42:0] HALF_MOD = 43'sd1288490188800;
    localparam logic signed [42:0] LIMIT    = 43'(AC_LIMIT);

    // base*300 + ext, built from shifts and adds (300 = 256 + 32 + 8 + 4).
    function automatic logic [41:0] to_ticks(input logic [32:0] base,
                                             input logic [8:0]  ext);
        logic [41:0] x;
        x = {9'd0, base};
        return (x << 8) + (x << 5) + (x << 3) + (x << 2) + {33'd0, ext};
    endfunction

    // ---------------------------------------------------------------- STC
    logic        prev_reg;
    logic        tick;
    logic [32:0] stc_base_reg;
    logic [8:0]  stc_ext_reg;
    logic        load_err_reg;

    assign tick = clk_27_in & ~prev_reg;

    always_ff @(posedge clk2) begin
        if (!rstn) begin
            // prev starts high so a divider output already high at reset
            // release is not mistaken for a rising edge.
            prev_reg     <= 1'b1;
            stc_base_reg <= '0;
            stc_ext_reg  <= '0;
            load_err_reg <= 1'b0;
        end else begin
            prev_reg     <= clk_27_in;
            load_err_reg <= 1'b0;
            if (load_valid) begin
                // A load request always consumes this cycle's tick, even
                // when the load itself is rejected.
                if (load_ext <= 9'd299) begin
                    stc_base_reg <= load_base;
                    stc_ext_reg  <= load_ext;
                end else begin
                    load_err_reg <= 1'b1;
                end
            end else if (tick) begin
                if (stc_ext_reg == 9'd299) begin
                    stc_ext_reg  <= '0;
                    stc_base_reg <= stc_base_reg + 33'd1;  // wraps at 2^33
                end else begin
                    stc_ext_reg  <= stc_ext_reg + 9'd1;
                end
            end
        end
    end

    // ------------------------------------------------------ check pipeline
    // S1: both times converted to ticks; the STC used is the value held in
    // the strobe cycle, before any tick or load of that cycle lands.
    logic               s1_valid_reg;
    logic [41:0]        s1_rx_total_reg;
    logic [41:0]        s1_stc_total_reg;
    // S2: wrap-corrected difference.
    logic               s2_valid_reg;
    logic signed [42:0] s2_d_reg;
    logic signed [42:0] d_raw;
    logic signed [42:0] d_next;
    // S3: outputs.
    logic               delta_valid_reg;
    logic signed [42:0] delta_reg;
    logic               ac_err_reg;

    always_comb begin
        d_raw  = $signed({1'b0, s1_rx_total_reg}) - $signed({1'b0, s1_stc_total_reg});
        d_next = d_raw;
        if (d_raw > HALF_MOD) begin
            d_next = d_raw - MOD;
        end else if (d_raw < -HALF_MOD) begin
            d_next = d_raw + MOD;
        end
    end

    always_ff @(posedge clk2) begin
        if (!rstn) begin
            s1_valid_reg     <= 1'b0;
            s1_rx_total_reg  <= '0;
            s1_stc_total_reg <= '0;
            s2_valid_reg     <= 1'b0;
            s2_d_reg         <= '0;
            delta_valid_reg  <= 1'b0;
            delta_reg        <= '0;
            ac_err_reg       <= 1'b0;
        end else begin
            s1_valid_reg <= check_valid;
            if (check_valid) begin
                s1_rx_total_reg  <= to_ticks(check_base, check_ext);
                s1_stc_total_reg <= to_ticks(stc_base_reg, stc_ext_reg);
            end

            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_d_reg <= d_next;
            end

            // delta / ac_err hold their last values between results.
            delta_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                delta_reg  <= s2_d_reg;
                ac_err_reg <= (s2_d_reg > LIMIT) || (s2_d_reg < -LIMIT);
            end
        end
    end

    assign stc_base    = stc_base_reg;
    assign stc_ext     = stc_ext_reg;
    assign load_err    = load_err_reg;
    assign delta_valid = delta_valid_reg;
    assign delta       = delta_reg;
    assign ac_err      = ac_err_reg;

endmodule

// File: tb/tb_stc_counter.sv
// -----------------------------------------------------------------------------
// tb_stc_counter
//
// Directed bench for stc_counter. A reference model keeps the STC as a single
// tick count modulo 2^33*300 and the pending check results as a queue of
// (due cycle, drift) entries. A compare process checks every DUT output
// against that model on each falling edge; hand-computed literal expectations
// pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_stc_counter;

    localparam longint MODV     = 64'd2576980377600;
    localparam longint MAX_BASE = 64'd8589934591;      // 2^33-1

    logic        clk2 = 1'b0;
    logic        rstn;
    logic        clk_27_in;
    logic        load_valid;
    logic [32:0] load_base;
    logic [8:0]  load_ext;
    logic        check_valid;
    logic [32:0] check_base;
    logic [8:0]  check_ext;
    logic [32:0] stc_base;
    logic [8:0]  stc_ext;
    logic        load_err;
    logic        delta_valid;
    logic signed [42:0] delta;
    logic        ac_err;

    stc_counter #(.AC_LIMIT(14)) dut (
        .clk2        (clk2),
        .rstn        (rstn),
        .clk_27_in   (clk_27_in),
        .load_valid  (load_valid),
        .load_base   (load_base),
        .load_ext    (load_ext),
        .check_valid (check_valid),
        .check_base  (check_base),
        .check_ext   (check_ext),
        .stc_base    (stc_base),
        .stc_ext     (stc_ext),
        .load_err    (load_err),
        .delta_valid (delta_valid),
        .delta       (delta),
        .ac_err      (ac_err)
    );

    always #5 clk2 = ~clk2;

    int n_checks   = 0;
    int n_failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    typedef struct {
        longint due;
        longint d;
    } result_t;

    result_t q[$];
    longint  cyc       = 0;
    longint  m_total   = 0;
    bit      m_prev    = 1'b1;
    bit      m_load_err = 1'b0;
    bit      m_valid   = 1'b0;
    longint  m_delta   = 0;
    bit      m_ac      = 1'b0;
    bit      started   = 1'b0;

    // Advance one clk2 cycle: the model absorbs the inputs present at the
    // rising edge, then the task returns at the following falling edge.
    task automatic step();
        bit     tk;
        longint pre;
        longint d;
        @(posedge clk2);
        cyc++;
        if (!rstn) begin
            q.delete();
            m_total    = 0;
            m_prev     = 1'b1;
            m_load_err = 1'b0;
            m_valid    = 1'b0;
            m_delta    = 0;
            m_ac       = 1'b0;
        end else begin
            tk         = clk_27_in && !m_prev;
            m_prev     = clk_27_in;
            pre        = m_total;
            m_load_err = 1'b0;
            if (load_valid) begin
                if (load_ext <= 9'd299)
                    m_total = longint'(load_base) * 300 + longint'(load_ext);
                else
                    m_load_err = 1'b1;
            end else if (tk) begin
                m_total = (m_total + 1) % MODV;
            end
            if (check_valid) begin
                d = longint'(check_base) * 300 + longint'(check_ext) - pre;
                if (d > MODV / 2)       d -= MODV;
                else if (d < -MODV / 2) d += MODV;
                q.push_back('{cyc + 2, d});
            end
            m_valid = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_valid = 1'b1;
                m_delta = q[0].d;
                m_ac    = (q[0].d > 14) || (q[0].d < -14);
                void'(q.pop_front());
            end
        end
        started = 1'b1;
        @(negedge clk2);
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk2) begin
        if (started) begin
            chk("stc_base",    longint'(stc_base),    m_total / 300);
            chk("stc_ext",     longint'(stc_ext),     m_total % 300);
            chk("load_err",    longint'(load_err),    longint'(m_load_err));
            chk("delta_valid", longint'(delta_valid), longint'(m_valid));
            chk("delta",       longint'(delta),       m_delta);
            chk("ac_err",      longint'(ac_err),      longint'(m_ac));
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clk_27_in = 1'b0; step(); step();
            clk_27_in = 1'b1; step(); step();
        end
    endtask

    task automatic do_load(input longint b, input int e);
        load_valid = 1'b1;
        load_base  = 33'(b);
        load_ext   = 9'(e);
        step();
        load_valid = 1'b0;
    endtask

    task automatic expect_stc(input string name, input longint b, input int e);
        chk({name, "_base"}, longint'(stc_base), b);
        chk({name, "_ext"},  longint'(stc_ext),  longint'(e));
    endtask

    task automatic run_check(input string name, input longint b, input int e,
                             input longint exp_d, input bit exp_ac);
        check_valid = 1'b1;
        check_base  = 33'(b);
        check_ext   = 9'(e);
        step();
        check_valid = 1'b0;
        step();
        chk({name, "_early"}, longint'(delta_valid), 0);
        step();
        chk({name, "_valid"}, longint'(delta_valid), 1);
        chk({name, "_delta"}, longint'(delta), exp_d);
        chk({name, "_ac"},    longint'(ac_err), longint'(exp_ac));
        step();
        chk({name, "_pulse"}, longint'(delta_valid), 0);
    endtask

    initial begin
        rstn = 1'b0; clk_27_in = 1'b1;
        load_valid = 1'b0; load_base = '0; load_ext = '0;
        check_valid = 1'b0; check_base = '0; check_ext = '0;

        // 1. Reset with the divider output high, then free run.
        step(); step(); step();
        rstn = 1'b1;
        step(); step(); step();
        expect_stc("rst_hold", 0, 0);
        chk("rst_load_err", longint'(load_err), 0);
        chk("rst_dvalid",   longint'(delta_valid), 0);
        do_ticks(300);
        expect_stc("free_run", 1, 0);

        // 2. Base wrap and extension rollover.
        do_load(MAX_BASE, 299);
        expect_stc("load_max", MAX_BASE, 299);
        do_ticks(1);
        expect_stc("base_wrap", 0, 0);
        do_load(5, 298);
        do_ticks(2);
        expect_stc("ext_roll", 6, 0);

        // 3. Load validation and load-over-tick priority.
        do_load(77, 300);
        chk("ld_err_pulse", longint'(load_err), 1);
        expect_stc("ld_rejected", 6, 0);
        step();
        chk("ld_err_clear", longint'(load_err), 0);
        clk_27_in = 1'b0; step();
        clk_27_in = 1'b1;
        do_load(100, 7);
        expect_stc("ld_over_tick", 100, 7);
        step(); step();
        expect_stc("ld_tick_gone", 100, 7);

        // 4. Drift against a frozen STC (divider held high: no ticks).
        do_load(1000, 0);
        run_check("drift_p20",  1000, 20, 20, 1'b1);
        run_check("drift_m10",  999, 290, -10, 1'b0);
        run_check("drift_p14",  1000, 14, 14, 1'b0);
        run_check("drift_m15",  999, 285, -15, 1'b1);

        // 5. Wrap-corrected drift.
        do_load(0, 5);
        run_check("wrap_neg", MAX_BASE, 299, -6, 1'b0);
        do_load(MAX_BASE, 299);
        run_check("wrap_pos", 0, 3, 4, 1'b0);

        // Load, check and tick together: check sees the old STC, load wins.
        do_load(1000, 0);
        clk_27_in = 1'b0; step();
        clk_27_in = 1'b1;
        load_valid = 1'b1; load_base = 33'd50; load_ext = 9'd0;
        check_valid = 1'b1; check_base = 33'd1000; check_ext = 9'd3;
        step();
        load_valid = 1'b0; check_valid = 1'b0;
        expect_stc("simul_stc", 50, 0);
        step(); step();
        chk("simul_valid", longint'(delta_valid), 1);
        chk("simul_delta", longint'(delta), 3);

        // 6. Back-to-back checks against STC (50, 0) = 15000 ticks.
        check_valid = 1'b1;
        check_base = 33'd50; check_ext = 9'd1;   step();
        check_base = 33'd49; check_ext = 9'd280; step();
        check_base = 33'd51; check_ext = 9'd0;   step();
        check_valid = 1'b0;
        chk("b2b0_valid", longint'(delta_valid), 1);
        chk("b2b0_delta", longint'(delta), 1);
        step();
        chk("b2b1_valid", longint'(delta_valid), 1);
        chk("b2b1_delta", longint'(delta), -20);
        step();
        chk("b2b2_valid", longint'(delta_valid), 1);
        chk("b2b2_delta", longint'(delta), 300);
        chk("b2b2_ac",    longint'(ac_err), 1);
        step();
        chk("b2b_end", longint'(delta_valid), 0);

        // Reset while results are in flight.
        check_valid = 1'b1; check_base = 33'd60; check_ext = 9'd0;
        step(); step();
        check_valid = 1'b0;
        rstn = 1'b0;
        step(); step();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_flight_dvalid", longint'(delta_valid), 0);
        end
        expect_stc("rst_flight", 0, 0);
        chk("rst_flight_delta", longint'(delta), 0);
        chk("rst_flight_ac",    longint'(ac_err), 0);
        // Divider still high after reset: needs low then high for a tick.
        step(); step();
        expect_stc("rst_no_tick", 0, 0);
        do_ticks(1);
        expect_stc("rst_first_tick", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
